btn_step_counter: RTL

Parametrised, debounced up/down counter driven by two raw push-buttons, with wrap or saturate overflow, optional auto-repeat while a button is held, and direct LED drive. It sits between the board buttons and LEDs as the next generation of the single-button top-level counter. It adds:
- a second button for down-counting
- synchronisation and debouncing on both buttons
- configurable width and step
- overflow status pulses

---
 rtl/btn_step_counter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/btn_step_counter.sv
// Debounced up/down step counter driven by two raw active-low push-buttons,
// with wrap or saturate overflow, optional auto-repeat and direct LED drive.

// One button front end: 2-FF synchroniser, counting debouncer, press/repeat events.
module btn_step_counter_btn #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned REPEAT_CYCLES   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic step
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          deb;
  logic [DW-1:0] dcnt;
  logic          accept;
  logic          press;
  logic          rep;

  // accept marks the edge at which deb takes the synchronised level
  assign accept = (s2 != deb) && (dcnt == DLAST);
  assign press  = accept && deb;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      deb  <= 1'b1;
      dcnt <= '0;
    end else begin
      s1 <= btn_n;
      s2 <= s1;
      if (s2 == deb) begin
        dcnt <= '0;
      end else if (accept) begin
        deb  <= s2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + DW'(1);
      end
    end
  end

  generate
    if (REPEAT_CYCLES > 0) begin : g_repeat
      localparam int unsigned RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
      localparam logic [RW-1:0] RLAST = RW'(REPEAT_CYCLES - 1);

      logic [RW-1:0] rtimer;

      // No repeat on the edge that accepts the release: the button is no longer held.
      assign rep = !deb && !accept && (rtimer == RLAST);

      always_ff @(posedge clk) begin
        if (rst || deb || rep) begin
          rtimer <= '0;
        end else begin
          rtimer <= rtimer + RW'(1);
        end
      end
    end else begin : g_no_repeat
      assign rep = 1'b0;
    end
  endgenerate

  assign step = press || rep;

endmodule

module btn_step_counter #(
  parameter int unsigned WIDTH           = 6,
  parameter int unsigned STEP            = 1,
  parameter int unsigned RESET_VALUE     = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned REPEAT_CYCLES   = 0,
  parameter int unsigned SATURATE        = 0,
  parameter int unsigned LED_ACTIVE_LOW  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_inc_n,
  input  logic             btn_dec_n,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] led,
  output logic             changed,
  output logic             limit
);

  localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] MAX_CNT = '1;

  logic             inc_step;
  logic             dec_step;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] count_nxt;
  logic             limit_nxt;

  function automatic logic [WIDTH-1:0] led_enc(input logic [WIDTH-1:0] value);
    return (LED_ACTIVE_LOW != 0) ? ~value : value;
  endfunction

  btn_step_counter_btn #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_inc (
    .clk  (clk),
    .rst  (rst),
    .btn_n(btn_inc_n),
    .step (inc_step)
  );

  btn_step_counter_btn #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_dec (
    .clk  (clk),
    .rst  (rst),
    .btn_n(btn_dec_n),
    .step (dec_step)
  );

  // The extra top bit of sum/diff is the carry/borrow out of the WIDTH-bit count.
  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    sum       = {1'b0, count} + STEP_X;
    diff      = {1'b0, count} - STEP_X;
    count_nxt = count;
    limit_nxt = 1'b0;
    if (inc_step && !dec_step) begin
      limit_nxt = sum[WIDTH];
      count_nxt = (SATURATE != 0 && sum[WIDTH]) ? MAX_CNT : sum[WIDTH-1:0];
    end else if (dec_step && !inc_step) begin
      limit_nxt = diff[WIDTH];
      count_nxt = (SATURATE != 0 && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= RST_CNT;
      led     <= led_enc(RST_CNT);
      changed <= 1'b0;
      limit   <= 1'b0;
    end else begin
      count   <= count_nxt;
      led     <= led_enc(count_nxt);
      changed <= (count_nxt != count);
      limit   <= limit_nxt;
    end
  end

endmodule
